// File: rtl/sqrt_sched_pkg.sv
// Shared types and helpers for the square-root scheduler.
package sqrt_sched_pkg;

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP} state_t;

  localparam int SQRT_DATA_W = 16;
  localparam int RR_MAX      = 8;

  // Round-robin one-hot pick over up to RR_MAX requesters; search starts at ptr and wraps at n.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input logic [2:0]        ptr,
                                                input int                n);
    logic [RR_MAX-1:0] g;
    logic              found;
    int                idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/sqrt_sched_rr_arbiter.sv
// Combinational round-robin select; the pointer register lives in the scheduler.
module rr_arbiter
  import sqrt_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [RR_MAX-1:0] req_ext;
  logic [RR_MAX-1:0] pick;
  logic [2:0]        ptr_ext;
  logic              unused_pick;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    ptr_ext              = '0;
    ptr_ext[ID_W-1:0]    = ptr;
  end

  assign pick        = rr_pick(req_ext, ptr_ext, NUM_REQ);
  assign gnt         = pick[NUM_REQ-1:0];
  assign unused_pick = ^pick;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) gnt_idx = ID_W'(i);
  end

endmodule

// File: rtl/sqrt_sched.sv
// Round-robin scheduler sharing one iterative sqrt unit among NUM_REQ requesters.
// Optional watchdog abort: define SQRT_SCHED_TIMEOUT_EN.
module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_W         = SQRT_DATA_W,
  parameter  int TIMEOUT_CYCLES = 96,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_num,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_res,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [DATA_W-1:0]         sq_num,
  output logic                      sq_ready,
  output logic                      sq_reset,
  input  logic                      sq_done,
  input  logic [DATA_W-1:0]         sq_res
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t              state, next_state;
  logic [ID_W-1:0]     ptr, cur_id, gnt_idx;
  logic [NUM_REQ-1:0]  gnt;
  logic                abort_q;
  logic                finish;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Abort wins over a coincident done: the unit is being reset in that cycle.
  assign finish   = (state == WAIT) && (abort_q || sq_done);
  assign busy     = (state != IDLE);
  assign sq_reset = reset | abort_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req_valid) next_state = GRANT;
      GRANT:   next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (abort_q || sq_done) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The pick is made on the IDLE->GRANT edge so grant outputs are visible during GRANT.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready <= '0;
      sq_ready  <= 1'b0;
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_res   <= '0;
      sq_num    <= '0;
      cur_id    <= '0;
      ptr       <= '0;
    end else begin
      req_ready <= '0;
      sq_ready  <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: if (|req_valid) begin
          req_ready <= gnt;
          cur_id    <= gnt_idx;
          sq_num    <= req_num[gnt_idx*DATA_W +: DATA_W];
        end
        GRANT: sq_ready <= 1'b1;
        WAIT: if (finish) begin
          rsp_valid <= ONE << cur_id;
          rsp_id    <= cur_id;
          rsp_res   <= abort_q ? '0 : sq_res;
        end
        RESP: ptr <= (cur_id == ID_W'(NUM_REQ-1)) ? '0 : cur_id + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SQRT_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog;
  logic            wdog_hit;

  assign wdog_hit = (state == WAIT) && !abort_q && !sq_done &&
                    (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog    <= '0;
      abort_q <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      abort_q <= wdog_hit;
      if (state == ISSUE)                wdog <= '0;
      else if (state == WAIT && !abort_q) wdog <= wdog + 1'b1;
      if (finish) rsp_err <= abort_q;
    end
  end
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
  assign abort_q = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule
